// File: rtl/matrix_storage_writer.sv
// Responder for the matrix-storage write interface: header words, then row-major element stream into BRAM.
// Optional feature macro WRITER_CHECKSUM_EN adds a running-XOR checksum written to base+3 after the last element.
module matrix_storage_writer #(
  parameter int SLOT_WORDS = 1152,
  parameter int ADDR_W     = 14,
  parameter int MAX_ROWS   = 32,
  parameter int MAX_COLS   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_request,
  output logic              write_ready,
  input  logic [2:0]        matrix_id,
  input  logic [7:0]        actual_rows,
  input  logic [7:0]        actual_cols,
  input  logic [7:0]        matrix_name [0:7],
  input  logic [31:0]       data_in,
  input  logic              data_valid,
  output logic              writer_ready,
  output logic              write_done,
  output logic              error,
  output logic              bram_wr_en,
  output logic [ADDR_W-1:0] bram_wr_addr,
  output logic [31:0]       bram_wr_data
);

  localparam int HDR_WORDS = 4;

`ifdef WRITER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, HDR3, STREAM, CKSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, HDR3, STREAM, DONE} state_t;
`endif

  state_t state_q, state_d;

  logic [7:0]        rows_q, cols_q;
  logic [7:0]        name_q [0:7];
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       total_q, count_q;
  logic              error_q;
`ifdef WRITER_CHECKSUM_EN
  logic [31:0]       cksum_q;
`endif

  logic accept, bad_dims, stream_fire, last_word;

  assign write_ready  = (state_q == IDLE) || (state_q == DONE);
  assign writer_ready = (state_q == STREAM);
  assign write_done   = (state_q == DONE);
  assign error        = error_q;

  assign accept      = write_request && write_ready;
  assign bad_dims    = (actual_rows == 8'd0) || (actual_cols == 8'd0) ||
                       (int'(actual_rows) > MAX_ROWS) || (int'(actual_cols) > MAX_COLS);
  assign stream_fire = (state_q == STREAM) && data_valid;
  assign last_word   = stream_fire && (count_q == total_q - 16'd1);

  // Slot base and element total are registered products so no multiply sits on the stream path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      for (int i = 0; i < 8; i++) name_q[i] <= '0;
      base_q  <= '0;
      total_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
`ifdef WRITER_CHECKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      error_q <= accept && bad_dims;
      if (accept && !bad_dims) begin
        rows_q  <= actual_rows;
        cols_q  <= actual_cols;
        for (int i = 0; i < 8; i++) name_q[i] <= matrix_name[i];
        base_q  <= ADDR_W'(matrix_id) * ADDR_W'(SLOT_WORDS);
        total_q <= 16'(actual_rows) * 16'(actual_cols);
        count_q <= '0;
`ifdef WRITER_CHECKSUM_EN
        cksum_q <= '0;
`endif
      end else if (stream_fire) begin
        count_q <= count_q + 16'd1;
`ifdef WRITER_CHECKSUM_EN
        cksum_q <= cksum_q ^ data_in;
`endif
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bram_wr_en   = 1'b0;
    bram_wr_addr = '0;
    bram_wr_data = '0;
    case (state_q)
      IDLE, DONE: begin
        if (write_request) state_d = bad_dims ? IDLE : HDR0;
      end
      HDR0: begin
        bram_wr_en   = 1'b1;
        bram_wr_addr = base_q;
        bram_wr_data = {rows_q, cols_q, 16'h0000};
        state_d      = HDR1;
      end
      HDR1: begin
        bram_wr_en   = 1'b1;
        bram_wr_addr = base_q + ADDR_W'(1);
        bram_wr_data = {name_q[0], name_q[1], name_q[2], name_q[3]};
        state_d      = HDR2;
      end
      HDR2: begin
        bram_wr_en   = 1'b1;
        bram_wr_addr = base_q + ADDR_W'(2);
        bram_wr_data = {name_q[4], name_q[5], name_q[6], name_q[7]};
        state_d      = HDR3;
      end
      HDR3: begin
        bram_wr_en   = 1'b1;
        bram_wr_addr = base_q + ADDR_W'(3);
        bram_wr_data = 32'h0;
        state_d      = STREAM;
      end
      STREAM: begin
        if (data_valid) begin
          bram_wr_en   = 1'b1;
          bram_wr_addr = base_q + ADDR_W'(HDR_WORDS) + ADDR_W'(count_q);
          bram_wr_data = data_in;
        end
`ifdef WRITER_CHECKSUM_EN
        if (last_word) state_d = CKSUM;
`else
        if (last_word) state_d = DONE;
`endif
      end
`ifdef WRITER_CHECKSUM_EN
      CKSUM: begin
        bram_wr_en   = 1'b1;
        bram_wr_addr = base_q + ADDR_W'(3);
        bram_wr_data = cksum_q;
        state_d      = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_storage_writer.sv
// Directed bench for matrix_storage_writer: expected BRAM write stream built from the slot layout rules,
// checked write-by-write, plus hand-computed memory and handshake expectations.
module tb_matrix_storage_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_request;
  logic        write_ready;
  logic [2:0]  matrix_id;
  logic [7:0]  actual_rows, actual_cols;
  logic [7:0]  matrix_name [0:7];
  logic [31:0] data_in;
  logic        data_valid;
  logic        writer_ready, write_done, error;
  logic        bram_wr_en;
  logic [13:0] bram_wr_addr;
  logic [31:0] bram_wr_data;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  logic [31:0] mem [int];
  logic [31:0] stimData[$];

  matrix_storage_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_request(write_request),
    .write_ready  (write_ready),
    .matrix_id    (matrix_id),
    .actual_rows  (actual_rows),
    .actual_cols  (actual_cols),
    .matrix_name  (matrix_name),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .writer_ready (writer_ready),
    .write_done   (write_done),
    .error        (error),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Every BRAM write must be the next entry of the expected stream; the image is kept for slot checks.
  always @(negedge clk) begin
    if (rst_n && bram_wr_en) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write_addr", 32'(bram_wr_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wr_addr", 32'(bram_wr_addr), 32'(e.addr));
        checkOutput("wr_data", bram_wr_data, e.data);
      end
      mem[int'(bram_wr_addr)] = bram_wr_data;
    end
  end

  // Slot layout: dims word, two name words, reserved/checksum word, then elements row-major.
  task automatic buildExpected(input int id, input int r, input int c, input logic [63:0] nm);
    int          base;
    logic [31:0] x;
    base = id * 1152;
    x    = 32'h0;
    expQ.push_back('{base,     {8'(r), 8'(c), 16'h0000}});
    expQ.push_back('{base + 1, nm[63:32]});
    expQ.push_back('{base + 2, nm[31:0]});
    expQ.push_back('{base + 3, 32'h0});
    for (int k = 0; k < r * c; k++) begin
      expQ.push_back('{base + 4 + k, stimData[k]});
      x = x ^ stimData[k];
    end
`ifdef WRITER_CHECKSUM_EN
    expQ.push_back('{base + 3, x});
`endif
  endtask

  task automatic applyStimulus(input int id, input int r, input int c, input logic [63:0] nm);
    checkOutput("write_ready_before_req", 32'(write_ready), 32'd1);
    write_request = 1'b1;
    matrix_id     = 3'(id);
    actual_rows   = 8'(r);
    actual_cols   = 8'(c);
    for (int i = 0; i < 8; i++) matrix_name[i] = nm[63 - 8*i -: 8];
    @(posedge clk); #1;
    write_request = 1'b0;
  endtask

  task automatic startMatrix(input int id, input int r, input int c, input logic [63:0] nm);
    int cyc;
    buildExpected(id, r, c, nm);
    applyStimulus(id, r, c, nm);
    checkOutput("write_ready_after_accept", 32'(write_ready), 32'd0);
    checkOutput("write_done_cleared", 32'(write_done), 32'd0);
    cyc = 1;
    while (!writer_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("writer_ready_latency", 32'(cyc), 32'd5);
  endtask

  task automatic streamWords(input int stopAfter, input bit gaps, output int readyCycles);
    int idx, cyc;
    idx = 0; cyc = 0; readyCycles = 0;
    while (idx < stopAfter && cyc < 200) begin
      data_in    = stimData[idx];
      data_valid = gaps ? (cyc % 3 == 0) : 1'b1;
      if (writer_ready) readyCycles++;
      @(posedge clk); #1;
      if (data_valid) idx++;
      cyc++;
    end
    data_valid = 1'b0;
    data_in    = 32'h0;
    if (idx < stopAfter) checkOutput("stream_timeout", 32'(idx), 32'(stopAfter));
  endtask

  task automatic finishMatrix();
    checkOutput("writer_ready_dropped", 32'(writer_ready), 32'd0);
`ifdef WRITER_CHECKSUM_EN
    checkOutput("write_done_during_cksum", 32'(write_done), 32'd0);
    @(posedge clk); #1;
`endif
    checkOutput("write_done_set", 32'(write_done), 32'd1);
    checkOutput("write_ready_in_done", 32'(write_ready), 32'd1);
    checkOutput("exp_queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic runMatrix(input int id, input int r, input int c, input logic [63:0] nm, input bit gaps);
    int rc;
    startMatrix(id, r, c, nm);
    streamWords(r * c, gaps, rc);
    if (!gaps) checkOutput("writer_ready_cycles", 32'(rc), 32'(r * c));
    finishMatrix();
  endtask

  task automatic rejectRequest(input int r, input int c);
    int wrs, notReady;
    wrs = 0; notReady = 0;
    applyStimulus(0, r, c, "REJECTED");
    checkOutput("error_pulse", 32'(error), 32'd1);
    checkOutput("reject_write_ready", 32'(write_ready), 32'd1);
    data_valid = 1'b1;
    data_in    = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) checkOutput("error_one_cycle", 32'(error), 32'd0);
      if (bram_wr_en) wrs++;
      if (!write_ready) notReady++;
    end
    data_valid = 1'b0;
    checkOutput("reject_no_writes", 32'(wrs), 32'd0);
    checkOutput("reject_ready_held", 32'(notReady), 32'd0);
    checkOutput("reject_no_done", 32'(write_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rc;
    rst_n = 1'b0; write_request = 1'b0; matrix_id = '0; actual_rows = '0; actual_cols = '0;
    for (int i = 0; i < 8; i++) matrix_name[i] = '0;
    data_in = '0; data_valid = 1'b0;
    #1;
    checkOutput("rst_write_ready", 32'(write_ready), 32'd1);
    checkOutput("rst_writer_ready", 32'(writer_ready), 32'd0);
    checkOutput("rst_write_done", 32'(write_done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_wr_en", 32'(bram_wr_en), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Invalid dimensions.
    rejectRequest(0, 3);
    rejectRequest(2, 33);

    // 2x3 continuous stream into slot 1.
    stimData = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    runMatrix(1, 2, 3, "ABCDEFGH", 1'b0);
    checkOutput("mem1152", mem[1152], 32'h0203_0000);
    checkOutput("mem1153", mem[1153], 32'h4142_4344);
    checkOutput("mem1154", mem[1154], 32'h4546_4748);
`ifdef WRITER_CHECKSUM_EN
    checkOutput("mem1155", mem[1155], 32'h0000_0001);
`else
    checkOutput("mem1155", mem[1155], 32'h0000_0000);
`endif
    checkOutput("mem1156", mem[1156], 32'd10);
    checkOutput("mem1161", mem[1161], 32'd15);

    // Same request with gaps on data_valid.
    mem.delete();
    runMatrix(1, 2, 3, "ABCDEFGH", 1'b1);
    checkOutput("gap_mem1152", mem[1152], 32'h0203_0000);
    checkOutput("gap_mem1158", mem[1158], 32'd12);
    checkOutput("gap_mem1161", mem[1161], 32'd15);
    checkOutput("gap_no_1162", 32'(mem.exists(1162)), 32'd0);

    // Back-to-back from DONE.
    stimData = '{32'd7};
    runMatrix(1, 1, 1, "SINGLE01", 1'b0);
    stimData = '{32'd8, 32'd9};
    runMatrix(2, 1, 2, "SECOND02", 1'b0);
    checkOutput("b2b_mem1156", mem[1156], 32'd7);
    checkOutput("b2b_mem2304", mem[2304], 32'h0102_0000);
    checkOutput("b2b_mem2308", mem[2308], 32'd8);
    checkOutput("b2b_mem2309", mem[2309], 32'd9);

    // Reset after three of six words.
    stimData = '{32'd31, 32'd32, 32'd33, 32'd34, 32'd35, 32'd36};
    startMatrix(3, 2, 3, "RESETME!");
    streamWords(3, 1'b0, rc);
    rst_n = 1'b0;
    #1;
    expQ.delete();
    checkOutput("midrst_write_ready", 32'(write_ready), 32'd1);
    checkOutput("midrst_writer_ready", 32'(writer_ready), 32'd0);
    checkOutput("midrst_write_done", 32'(write_done), 32'd0);
    checkOutput("midrst_error", 32'(error), 32'd0);
    checkOutput("midrst_wr_en", 32'(bram_wr_en), 32'd0);
    checkOutput("midrst_wr_addr", 32'(bram_wr_addr), 32'd0);
    checkOutput("midrst_wr_data", bram_wr_data, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    stimData = '{32'd21, 32'd22};
    runMatrix(3, 1, 2, "AFTERRST", 1'b0);
    checkOutput("postrst_mem3456", mem[3456], 32'h0102_0000);
    checkOutput("postrst_mem3460", mem[3460], 32'd21);
    checkOutput("postrst_mem3461", mem[3461], 32'd22);

    // Checksum word layout with 1,2,4,8.
    stimData = '{32'd1, 32'd2, 32'd4, 32'd8};
    runMatrix(0, 2, 2, "MATRIX01", 1'b0);
`ifdef WRITER_CHECKSUM_EN
    checkOutput("cksum_mem3", mem[3], 32'h0000_000F);
`else
    checkOutput("cksum_mem3", mem[3], 32'h0000_0000);
`endif
    checkOutput("cksum_mem7", mem[7], 32'd8);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
